// File: rtl/matmul_unit.sv
// Multi-cycle N x N signed matrix multiplier: C = A * B, one multiply-accumulate per cycle.
// Operands are loaded while idle; results are readable by address and streamed on Writedata.
module matmul_unit #(
    parameter int DATA_W = 32,
    parameter int N      = 4,
    parameter int AW     = $clog2(N*N),
    parameter int ACC_W  = 2*DATA_W + $clog2(N)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WrEn,
    input  logic              WrSel,
    input  logic [AW-1:0]     WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              Start,
    output logic              Busy,
    output logic              Done,
    input  logic [AW-1:0]     RdAddr,
    output logic [ACC_W-1:0]  RdData,
    output logic [ACC_W-1:0]  Writedata
);

    localparam int IW    = $clog2(N);
    localparam int PW    = 2*DATA_W;
    localparam int DEPTH = 1 << AW;
    localparam logic [IW-1:0] LAST = IW'(N-1);

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    state_t state, stateNext;

    logic signed [DATA_W-1:0] aMem [DEPTH];
    logic signed [DATA_W-1:0] bMem [DEPTH];
    logic [ACC_W-1:0]         cMem [DEPTH];

    logic [IW-1:0]        i, j, k;
    logic [ACC_W-1:0]     acc;
    logic signed [DATA_W-1:0] aOp, bOp;
    logic signed [PW-1:0] prod;
    logic [ACC_W-1:0]     prodExt;

    // Row-major element address: row*N + col
    function automatic logic [AW-1:0] idx(input logic [IW-1:0] row, input logic [IW-1:0] col);
        return AW'(row) * AW'(N) + AW'(col);
    endfunction

    assign aOp     = aMem[idx(i, k)];
    assign bOp     = bMem[idx(k, j)];
    assign prod    = PW'(aOp) * PW'(bOp);
    assign prodExt = {{(ACC_W-PW){prod[PW-1]}}, prod};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    stateNext = MAC;
                end
            end
            MAC: begin
                Busy = 1'b1;
                if (k == LAST) begin
                    stateNext = WRITE;
                end
            end
            WRITE: begin
                Busy      = 1'b1;
                stateNext = (i == LAST && j == LAST) ? DONE : MAC;
            end
            DONE: begin
                Done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Operands are only writable while idle, so A and B stay frozen for a whole run
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                aMem[e] <= '0;
                bMem[e] <= '0;
                cMem[e] <= '0;
            end
            i         <= '0;
            j         <= '0;
            k         <= '0;
            acc       <= '0;
            RdData    <= '0;
            Writedata <= '0;
        end else begin
            RdData <= cMem[RdAddr];
            case (state)
                IDLE: begin
                    if (WrEn) begin
                        if (WrSel) begin
                            bMem[WrAddr] <= WrData;
                        end else begin
                            aMem[WrAddr] <= WrData;
                        end
                    end
                    if (Start) begin
                        i   <= '0;
                        j   <= '0;
                        k   <= '0;
                        acc <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + prodExt;
                    k   <= k + IW'(1);
                end
                WRITE: begin
                    cMem[idx(i, j)] <= acc;
                    Writedata       <= acc;
                    acc             <= '0;
                    k               <= '0;
                    if (j == LAST) begin
                        j <= '0;
                        i <= i + IW'(1);
                    end else begin
                        j <= j + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_unit.sv
// Directed bench for matmul_unit (N=4): identity, signed, extreme values, handshake abuse,
// mid-run reset and back-to-back starts, with hand-computed expected results.
module tb_matmul_unit;

    localparam int DATA_W = 32;
    localparam int N      = 4;
    localparam int AW     = 4;
    localparam int ACC_W  = 66;
    localparam int NN     = 16;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              WrEn;
    logic              WrSel;
    logic [AW-1:0]     WrAddr;
    logic [DATA_W-1:0] WrData;
    logic              Start;
    logic              Busy;
    logic              Done;
    logic [AW-1:0]     RdAddr;
    logic [ACC_W-1:0]  RdData;
    logic [ACC_W-1:0]  Writedata;

    int assertCount = 0;
    int failCount   = 0;

    logic [DATA_W-1:0] matA [NN];
    logic [DATA_W-1:0] matB [NN];
    logic [ACC_W-1:0]  expC [NN];

    matmul_unit #(
        .DATA_W(DATA_W),
        .N     (N),
        .AW    (AW),
        .ACC_W (ACC_W)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .WrEn     (WrEn),
        .WrSel    (WrSel),
        .WrAddr   (WrAddr),
        .WrData   (WrData),
        .Start    (Start),
        .Busy     (Busy),
        .Done     (Done),
        .RdAddr   (RdAddr),
        .RdData   (RdData),
        .Writedata(Writedata)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [ACC_W-1:0] observed,
                               input logic [ACC_W-1:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic writeElem(input logic sel, input logic [AW-1:0] addr, input logic [DATA_W-1:0] data);
        WrEn   = 1'b1;
        WrSel  = sel;
        WrAddr = addr;
        WrData = data;
        @(negedge Clk);
        WrEn   = 1'b0;
    endtask

    task automatic loadOperands();
        for (int e = 0; e < NN; e++) writeElem(1'b0, AW'(e), matA[e]);
        for (int e = 0; e < NN; e++) writeElem(1'b1, AW'(e), matB[e]);
    endtask

    task automatic setIdentity();
        for (int e = 0; e < NN; e++) begin
            matA[e] = (e / N == e % N) ? 32'd1 : 32'd0;
            matB[e] = DATA_W'(e + 1);
            expC[e] = ACC_W'(e + 1);
        end
    endtask

    // Pulse Start (optionally with an A[0] write), follow the run to Done, check the stream and timing
    task automatic applyStimulus(input string tag, input int abuseCycle, input logic idleWrite,
                                 input logic [DATA_W-1:0] idleData);
        int busyCycles = 0;
        int doneCycle  = 0;
        Start = 1'b1;
        if (idleWrite) begin
            WrEn   = 1'b1;
            WrSel  = 1'b0;
            WrAddr = '0;
            WrData = idleData;
        end
        @(negedge Clk);
        for (int cyc = 1; cyc <= 90; cyc++) begin
            if (cyc == abuseCycle) begin
                Start  = 1'b1;
                WrEn   = 1'b1;
                WrSel  = 1'b0;
                WrAddr = '0;
                WrData = 32'd99;
            end else begin
                Start = 1'b0;
                WrEn  = 1'b0;
            end
            if (Busy) busyCycles++;
            if (cyc > 1 && cyc % 5 == 1 && cyc <= 81)
                checkOutput($sformatf("%s wd[%0d]", tag, cyc / 5 - 1), Writedata, expC[cyc / 5 - 1]);
            if (Done) begin
                doneCycle = cyc;
                break;
            end
            @(negedge Clk);
        end
        Start = 1'b0;
        WrEn  = 1'b0;
        checkOutput({tag, " busyCycles"}, ACC_W'(busyCycles), ACC_W'(80));
        checkOutput({tag, " doneCycle"}, ACC_W'(doneCycle), ACC_W'(81));
    endtask

    task automatic readBack(input string tag);
        for (int e = 0; e < NN; e++) begin
            RdAddr = AW'(e);
            @(negedge Clk);
            checkOutput($sformatf("%s rd[%0d]", tag, e), RdData, expC[e]);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Reset  = 1'b1;
        WrEn   = 1'b0;
        WrSel  = 1'b0;
        WrAddr = '0;
        WrData = '0;
        Start  = 1'b0;
        RdAddr = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checkOutput("reset Busy", ACC_W'(Busy), '0);
        checkOutput("reset Done", ACC_W'(Done), '0);
        checkOutput("reset RdData", RdData, '0);
        checkOutput("reset Writedata", Writedata, '0);

        setIdentity();
        loadOperands();
        applyStimulus("ident", 0, 1'b0, '0);
        readBack("ident");

        for (int e = 0; e < NN; e++) begin
            matA[e] = 32'hFFFF_FFFF;
            matB[e] = 32'd2;
            expC[e] = ACC_W'(-8);
        end
        loadOperands();
        applyStimulus("signed", 0, 1'b0, '0);
        RdAddr = 4'd5;
        @(negedge Clk);
        checkOutput("signed rd5", RdData, 66'h3_FFFF_FFFF_FFFF_FFF8);

        for (int e = 0; e < NN; e++) begin
            matA[e] = 32'h8000_0000;
            matB[e] = 32'h8000_0000;
            expC[e] = 66'h1_0000_0000_0000_0000;
        end
        loadOperands();
        applyStimulus("extreme", 0, 1'b0, '0);
        readBack("extreme");

        // Start and a write during the busy window must both be ignored
        setIdentity();
        loadOperands();
        applyStimulus("abuse", 10, 1'b0, '0);
        readBack("abuse");

        // A[0]=2 written together with Start is used: row 0 of C doubles
        for (int c = 0; c < N; c++) expC[c] = ACC_W'(2 * (c + 1));
        applyStimulus("idlewr", 0, 1'b1, 32'd2);
        @(negedge Clk);
        applyStimulus("b2b", 0, 1'b0, '0);
        readBack("b2b");

        RdAddr = 4'd15;
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (36) @(negedge Clk);
        checkOutput("midrun Busy", ACC_W'(Busy), ACC_W'(1));
        #2 Reset = 1'b1;
        #1;
        checkOutput("async Busy", ACC_W'(Busy), '0);
        checkOutput("async Done", ACC_W'(Done), '0);
        checkOutput("async Writedata", Writedata, '0);
        checkOutput("async RdData", RdData, '0);
        @(negedge Clk);
        Reset = 1'b0;
        for (int e = 0; e < NN; e++) expC[e] = '0;
        readBack("cleared");

        setIdentity();
        loadOperands();
        applyStimulus("rerun", 0, 1'b0, '0);
        readBack("rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
